// File: rtl/regfile_ctrl_pkg.sv
// regfile_ctrl_pkg
// Shared constants and types for the register-file controller:
// data width, register address width, FSM state encoding and the
// requester index constants used for the write-port request/grant vectors.
package regfile_ctrl_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    // Bit positions in the request/grant vectors.
    localparam int JMP = 0;
    localparam int WB  = 1;
    localparam int LSU = 2;

endpackage

// File: rtl/regfile_ctrl_scoreboard.sv
// rf_scoreboard
// Per-register pending-write scoreboard for registers 1..31. Register 0 is
// hard-wired and never becomes pending.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   set_en, set_idx     mark a register pending (issue accepted)
//   clr_en, clr_idx     clear a register (its write is being driven)
//   rs1, rs2, rd        hazard lookup addresses
//   hit_rs1/2, hit_rd   lookup results (always 0 for address 0)
//   pending_any         any register pending
module rf_scoreboard
    import regfile_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_idx,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_idx,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [REG_ADDR_W-1:0] rd,
    output logic                  hit_rs1,
    output logic                  hit_rs2,
    output logic                  hit_rd,
    output logic                  pending_any
);

    logic [NUM_REGS-1:1] pending;
    logic [NUM_REGS-1:1] pending_nxt;
    logic [NUM_REGS-1:0] pend_full;

    // Set and clear of different bits in the same cycle both apply.
    always_comb begin
        pending_nxt = pending;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (clr_en && clr_idx == REG_ADDR_W'(i))
                pending_nxt[i] = 1'b0;
            if (set_en && set_idx == REG_ADDR_W'(i))
                pending_nxt[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            pending <= '0;
        else
            pending <= pending_nxt;
    end

    assign pend_full   = {pending, 1'b0};
    assign hit_rs1     = pend_full[rs1];
    assign hit_rs2     = pend_full[rs2];
    assign hit_rd      = pend_full[rd];
    assign pending_any = |pending;

endmodule

// File: rtl/regfile_ctrl.sv
// regfile_ctrl
// Write-port arbiter and issue/halt controller for the 32x32 register file
// and PC. Jump, writeback and load/store return share one write bus; a
// pending scoreboard blocks issue on RAW/WAW hazards; a small FSM sequences
// a clean halt.
// Optional build macro REGFILE_CTRL_PERF_EN adds perf_stall_cnt and
// perf_conflict_cnt saturating counters.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   halt_req                 level halt request
//   issue_*                  instruction issue request / issue_ready
//   jmp_*, wb_*, lsu_*       write-port requesters (valid/payload/ready)
//   rf_*                     registered register-file controls
//   halted                   halt status
//
//   state  | meaning
//   RUN    | normal operation, issue allowed
//   DRAIN  | halt requested, issue blocked, outstanding writes finish
//   HALTED | register file frozen, all grants withheld
module regfile_ctrl #(
    parameter int XLEN         = regfile_ctrl_pkg::XLEN,
    parameter int STARVE_LIMIT = 4,
    parameter int SCNT_W       = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            halt_req,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rs1,
    input  logic [4:0]      issue_rs2,
    input  logic [4:0]      issue_rd,
    input  logic            issue_rd_we,
    output logic            issue_ready,
    input  logic            jmp_valid,
    input  logic [XLEN-1:0] jmp_target,
    output logic            jmp_ready,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            wb_ready,
    input  logic            lsu_valid,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,
    output logic            rf_rd_wrn,
    output logic [4:0]      rf_rd_offset,
    output logic [XLEN-1:0] rf_data_in,
    output logic            rf_update_pc,
    output logic            rf_freeze_pc,
    output logic            rf_halt,
`ifdef REGFILE_CTRL_PERF_EN
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_conflict_cnt,
`endif
    output logic            halted
);

    import regfile_ctrl_pkg::*;

    state_t              state, state_nxt;
    logic [SCNT_W-1:0]   scnt;
    logic [2:0]          req, gnt;
    logic                active, lsu_over;
    logic                hit_rs1, hit_rs2, hit_rd, pending_any;
    logic                issue_acc;

    assign req[JMP] = jmp_valid;
    assign req[WB]  = wb_valid;
    assign req[LSU] = lsu_valid;

    assign active   = (state != HALTED);
    assign lsu_over = (scnt == SCNT_W'(STARVE_LIMIT));

    // Jump always wins; a starved load return outranks writeback.
    always_comb begin
        gnt = 3'b000;
        if (active) begin
            if (req[JMP])
                gnt[JMP] = 1'b1;
            else if (req[LSU] && (lsu_over || !req[WB]))
                gnt[LSU] = 1'b1;
            else if (req[WB])
                gnt[WB] = 1'b1;
        end
    end

    assign jmp_ready = gnt[JMP];
    assign wb_ready  = gnt[WB];
    assign lsu_ready = gnt[LSU];

    assign issue_ready = (state == RUN) && !hit_rs1 && !hit_rs2 &&
                         !(issue_rd_we && hit_rd) && !jmp_valid;
    assign issue_acc   = issue_valid && issue_ready;

    rf_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .set_en      (issue_acc && issue_rd_we && issue_rd != 5'd0),
        .set_idx     (issue_rd),
        .clr_en      (!rf_rd_wrn),
        .clr_idx     (rf_rd_offset),
        .rs1         (issue_rs1),
        .rs2         (issue_rs2),
        .rd          (issue_rd),
        .hit_rs1     (hit_rs1),
        .hit_rs2     (hit_rs2),
        .hit_rd      (hit_rd),
        .pending_any (pending_any)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:    if (halt_req) state_nxt = DRAIN;
            DRAIN: begin
                if (!halt_req)
                    state_nxt = RUN;
                else if (!pending_any && rf_rd_wrn && !rf_update_pc)
                    state_nxt = HALTED;
            end
            HALTED: if (!halt_req) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            scnt         <= '0;
            rf_rd_wrn    <= 1'b1;
            rf_rd_offset <= '0;
            rf_data_in   <= '0;
            rf_update_pc <= 1'b0;
            rf_freeze_pc <= 1'b1;
            rf_halt      <= 1'b0;
            halted       <= 1'b0;
        end else begin
            state <= state_nxt;

            // Saturates at the limit so the override persists while blocked.
            if (gnt[LSU])
                scnt <= '0;
            else if (lsu_valid && !lsu_over)
                scnt <= scnt + 1'b1;

            rf_rd_wrn    <= !(gnt[WB] || gnt[LSU]);
            rf_update_pc <= gnt[JMP];
            if (gnt[WB]) begin
                rf_rd_offset <= wb_rd;
                rf_data_in   <= wb_data;
            end else if (gnt[LSU]) begin
                rf_rd_offset <= lsu_rd;
                rf_data_in   <= lsu_data;
            end else if (gnt[JMP]) begin
                rf_rd_offset <= '0;
                rf_data_in   <= jmp_target;
            end else begin
                rf_rd_offset <= '0;
                rf_data_in   <= '0;
            end

            rf_freeze_pc <= gnt[JMP] ? 1'b0 :
                            ((issue_valid && !issue_ready) || state != RUN);
            rf_halt      <= (state_nxt == HALTED);
            halted       <= (state_nxt == HALTED);
        end
    end

`ifdef REGFILE_CTRL_PERF_EN
    logic conflict;
    assign conflict = (req[JMP] && req[WB]) || (req[JMP] && req[LSU]) ||
                      (req[WB] && req[LSU]);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt    <= '0;
            perf_conflict_cnt <= '0;
        end else begin
            if (issue_valid && !issue_ready && perf_stall_cnt != 32'hFFFF_FFFF)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (conflict && perf_conflict_cnt != 32'hFFFF_FFFF)
                perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_ctrl.sv
// tb_regfile_ctrl
// Directed bench for regfile_ctrl: hazard stall, write-port priority,
// load-return starvation override, rd=0 writes, halt sequencing and reset
// from DRAIN. Inputs change 1 time unit after the rising edge; outputs are
// sampled 2 time units after it.
module tb_regfile_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt_req;
    logic        issue_valid;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_rd_we;
    logic        issue_ready;
    logic        jmp_valid;
    logic [31:0] jmp_target;
    logic        jmp_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic        rf_rd_wrn;
    logic [4:0]  rf_rd_offset;
    logic [31:0] rf_data_in;
    logic        rf_update_pc, rf_freeze_pc, rf_halt, halted;
`ifdef REGFILE_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt, perf_conflict_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .halt_req     (halt_req),
        .issue_valid  (issue_valid),
        .issue_rs1    (issue_rs1),
        .issue_rs2    (issue_rs2),
        .issue_rd     (issue_rd),
        .issue_rd_we  (issue_rd_we),
        .issue_ready  (issue_ready),
        .jmp_valid    (jmp_valid),
        .jmp_target   (jmp_target),
        .jmp_ready    (jmp_ready),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_ready     (wb_ready),
        .lsu_valid    (lsu_valid),
        .lsu_rd       (lsu_rd),
        .lsu_data     (lsu_data),
        .lsu_ready    (lsu_ready),
        .rf_rd_wrn    (rf_rd_wrn),
        .rf_rd_offset (rf_rd_offset),
        .rf_data_in   (rf_data_in),
        .rf_update_pc (rf_update_pc),
        .rf_freeze_pc (rf_freeze_pc),
        .rf_halt      (rf_halt),
`ifdef REGFILE_CTRL_PERF_EN
        .perf_stall_cnt    (perf_stall_cnt),
        .perf_conflict_cnt (perf_conflict_cnt),
`endif
        .halted       (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic we);
        issue_valid = v;
        issue_rs1   = rs1;
        issue_rs2   = rs2;
        issue_rd    = rd;
        issue_rd_we = we;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_wrn"},    32'(rf_rd_wrn),    32'd1);
        chk({pfx, "_offset"}, 32'(rf_rd_offset), 32'd0);
        chk({pfx, "_data"},   rf_data_in,        32'd0);
        chk({pfx, "_upd"},    32'(rf_update_pc), 32'd0);
        chk({pfx, "_frz"},    32'(rf_freeze_pc), 32'd1);
        chk({pfx, "_halt"},   32'(rf_halt),      32'd0);
        chk({pfx, "_halted"}, 32'(halted),       32'd0);
    endtask

    initial begin
        rst = 1'b1; halt_req = 1'b0;
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        jmp_valid = 1'b0; jmp_target = '0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;

        // Reset state
        tick(); tick();
        chk_reset_outputs("rst");
        rst = 1'b0;
        settle();
        chk("rst_issue_ready", 32'(issue_ready), 32'd1);

        // RAW stall on rd=5 until its writeback is driven
        issue(1'b1, 5'd1, 5'd2, 5'd5, 1'b1);
        settle();
        chk("raw_first_ready", 32'(issue_ready), 32'd1);
        tick();
        issue(1'b1, 5'd5, 5'd0, 5'd6, 1'b1);
        settle();
        chk("raw_stall_ready", 32'(issue_ready), 32'd0);
        chk("raw_frz_after_acc", 32'(rf_freeze_pc), 32'd0);
        tick();
        chk("raw_frz_stall", 32'(rf_freeze_pc), 32'd1);
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
        settle();
        chk("raw_wb_ready", 32'(wb_ready), 32'd1);
        tick();
        wb_valid = 1'b0;
        settle();
        chk("raw_wb_wrn", 32'(rf_rd_wrn), 32'd0);
        chk("raw_wb_off", 32'(rf_rd_offset), 32'd5);
        chk("raw_wb_data", rf_data_in, 32'h1234);
        chk("raw_still_stall", 32'(issue_ready), 32'd0);
        chk("raw_frz_still", 32'(rf_freeze_pc), 32'd1);
        tick();
        chk("raw_release_ready", 32'(issue_ready), 32'd1);
        chk("raw_idle_wrn", 32'(rf_rd_wrn), 32'd1);
        tick();
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("raw_frz_accept", 32'(rf_freeze_pc), 32'd0);
        // WAW on rd=6 now pending
        issue(1'b1, 5'd0, 5'd0, 5'd6, 1'b1);
        settle();
        chk("waw_stall", 32'(issue_ready), 32'd0);
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h6;
        tick();
        wb_valid = 1'b0;
        tick();

        // Jump beats writeback
        jmp_valid = 1'b1; jmp_target = 32'h40;
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
        settle();
        chk("pri_jmp_ready", 32'(jmp_ready), 32'd1);
        chk("pri_wb_blocked", 32'(wb_ready), 32'd0);
        chk("pri_issue_blocked", 32'(issue_ready), 32'd0);
        tick();
        jmp_valid = 1'b0;
        settle();
        chk("pri_upd_pc", 32'(rf_update_pc), 32'd1);
        chk("pri_pc_data", rf_data_in, 32'h40);
        chk("pri_jmp_wrn", 32'(rf_rd_wrn), 32'd1);
        chk("pri_jmp_frz", 32'(rf_freeze_pc), 32'd0);
        chk("pri_wb_ready2", 32'(wb_ready), 32'd1);
        tick();
        wb_valid = 1'b0;
        chk("pri_wb_wrn", 32'(rf_rd_wrn), 32'd0);
        chk("pri_wb_off", 32'(rf_rd_offset), 32'd3);
        chk("pri_wb_data", rf_data_in, 32'h33);
        chk("pri_wb_upd", 32'(rf_update_pc), 32'd0);
        tick();

        // Load-return starvation override
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h77;
        lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'h88;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("starve_lsu_wait%0d", i), 32'(lsu_ready), 32'd0);
            chk($sformatf("starve_wb_win%0d", i), 32'(wb_ready), 32'd1);
            tick();
        end
        settle();
        chk("starve_lsu_win", 32'(lsu_ready), 32'd1);
        chk("starve_wb_lose", 32'(wb_ready), 32'd0);
        tick();
        lsu_rd = 5'd9; lsu_data = 32'h99;
        settle();
        chk("starve_lsu_off", 32'(rf_rd_offset), 32'd8);
        chk("starve_lsu_data", rf_data_in, 32'h88);
        chk("starve_scnt_clear", 32'(lsu_ready), 32'd0);
        wb_valid = 1'b0; lsu_valid = 1'b0;
        tick();

        // Write to rd=0
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
        tick();
        wb_valid = 1'b0;
        issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
        settle();
        chk("r0_wrn", 32'(rf_rd_wrn), 32'd0);
        chk("r0_off", 32'(rf_rd_offset), 32'd0);
        chk("r0_data", rf_data_in, 32'hDEAD);
        chk("r0_issue_ready", 32'(issue_ready), 32'd1);
        tick();
        settle();
        chk("r0_not_pending", 32'(issue_ready), 32'd1);
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();

        // Halt with two loads pending
        issue(1'b1, 5'd0, 5'd0, 5'd10, 1'b1);
        tick();
        issue(1'b1, 5'd0, 5'd0, 5'd11, 1'b1);
        tick();
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        halt_req = 1'b1;
        tick();
        settle();
        chk("drain_issue_blocked", 32'(issue_ready), 32'd0);
        chk("drain_not_halted", 32'(halted), 32'd0);
        lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'hA0;
        settle();
        chk("drain_lsu_ready", 32'(lsu_ready), 32'd1);
        tick();
        lsu_rd = 5'd11; lsu_data = 32'hB1;
        chk("drain_ld1_off", 32'(rf_rd_offset), 32'd10);
        chk("drain_ld1_data", rf_data_in, 32'hA0);
        tick();
        lsu_valid = 1'b0;
        chk("drain_ld2_off", 32'(rf_rd_offset), 32'd11);
        chk("drain_ld2_wrn", 32'(rf_rd_wrn), 32'd0);
        chk("drain_ld2_halted", 32'(halted), 32'd0);
        tick();
        chk("drain_last_halted", 32'(halted), 32'd0);
        chk("drain_frz", 32'(rf_freeze_pc), 32'd1);
        tick();
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_rf_halt", 32'(rf_halt), 32'd1);
        chk("halt_frz", 32'(rf_freeze_pc), 32'd1);
        jmp_valid = 1'b1; wb_valid = 1'b1; wb_rd = 5'd1;
        issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        settle();
        chk("halt_jmp_ready", 32'(jmp_ready), 32'd0);
        chk("halt_wb_ready", 32'(wb_ready), 32'd0);
        chk("halt_issue_ready", 32'(issue_ready), 32'd0);
        jmp_valid = 1'b0; wb_valid = 1'b0;
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        halt_req = 1'b0;
        tick();
        chk("resume_halted", 32'(halted), 32'd0);
        chk("resume_rf_halt", 32'(rf_halt), 32'd0);
        chk("resume_issue_ready", 32'(issue_ready), 32'd1);
        tick();

        // Reset while draining with pending writes to 12 and 13
        issue(1'b1, 5'd0, 5'd0, 5'd12, 1'b1);
        tick();
        issue(1'b1, 5'd0, 5'd0, 5'd13, 1'b1);
        tick();
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        halt_req = 1'b1;
        tick();
        wb_valid = 1'b1; wb_rd = 5'd12; wb_data = 32'hC;
        tick();
        wb_valid = 1'b0;
        chk("rstdrain_wb_wrn", 32'(rf_rd_wrn), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        halt_req = 1'b0;
        chk_reset_outputs("rstdrain");
        issue(1'b1, 5'd13, 5'd12, 5'd13, 1'b1);
        settle();
        chk("rstdrain_issue_ready", 32'(issue_ready), 32'd1);
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_ctrl.md
Name: regfile_ctrl

Overview:
Controller and write-port arbiter for the 32x32 general-purpose register file and its program counter (PC).
- Three requesters share the single write-data bus (reg_data_in): jump unit (PC load), writeback stage, load/store return.
- Holds a per-register pending scoreboard and stalls issue on read-after-write (RAW) and write-after-write (WAW) hazards.
- Drives the register file's rd/wrn, offset, data, update_pc, freeze_pc and halt controls, and sequences a clean halt.

Parameters:
XLEN, 32, data/PC width
STARVE_LIMIT, 4, consecutive lost cycles before the load/store return overrides writeback priority
SCNT_W, 3, starvation counter width; must satisfy 2^SCNT_W > STARVE_LIMIT

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
halt_req  in  1  request CPU halt; level-sensitive
issue_valid  in  1  decoded instruction wants to issue
issue_rs1  in  5  source register 1
issue_rs2  in  5  source register 2
issue_rd  in  5  destination register
issue_rd_we  in  1  instruction writes rd
issue_ready  out  1  issue accepted this cycle
jmp_valid  in  1  PC redirect request
jmp_target  in  XLEN  new PC
jmp_ready  out  1  grant
wb_valid  in  1  writeback request
wb_rd  in  5  writeback destination
wb_data  in  XLEN  writeback data
wb_ready  out  1  grant
lsu_valid  in  1  load-return request
lsu_rd  in  5  load-return destination
lsu_data  in  XLEN  load-return data
lsu_ready  out  1  grant
rf_rd_wrn  out  1  0 = write rf_rd_offset
rf_rd_offset  out  5  write address
rf_data_in  out  XLEN  write data or PC target
rf_update_pc  out  1  load PC from rf_data_in
rf_freeze_pc  out  1  hold PC
rf_halt  out  1  freeze register file
halted  out  1  status

Behaviour:
Handshake
- Requesters hold valid and payload stable until their ready is high.
- Ready outputs are combinational from the current state and inputs.
- Grant in cycle N → rf_* driven from registers in cycle N+1; the register file commits at the end of N+1.

Write-port priority
- Priority order: jump > writeback > load/store return.
- Only one grant per cycle.
- Jump grant: rf_update_pc=1, rf_rd_wrn=1, rf_data_in=jmp_target.

Starvation counter (scnt)
- Increments each cycle lsu_valid is high and lsu_ready is low.
- Clears on an lsu grant.
- When scnt==STARVE_LIMIT: lsu outranks wb for that cycle. Jump still wins.

Scoreboard, pending[31:1]
- Set: issue accepted with issue_rd_we=1 and issue_rd!=0.
- Clear: when the corresponding write is driven (cycle N+1).
- A write to rd=0 is granted but never marked pending; rf_rd_offset=0 is still driven, and the register file discards it.
- Same-cycle set and clear of different bits both take effect. The same bit cannot coincide, because WAW blocks the issue.

Issue gating
- issue_ready = state==RUN && !pending[rs1] && !pending[rs2] && !(issue_rd_we && pending[rd]) && !jmp_valid.
- pending[0] reads as 0.
- rf_freeze_pc (registered) = 1 when issue_valid && !issue_ready, or when state!=RUN; otherwise 0.
- rf_update_pc overrides freeze.

FSM
- RUN → DRAIN on halt_req.
- DRAIN: issue blocked; wb/lsu/jmp still granted. DRAIN → HALTED when pending==0 and no grant is outstanding in the output register.
- DRAIN → RUN if halt_req drops.
- HALTED: rf_halt=1, halted=1, rf_freeze_pc=1, all readies 0. HALTED → RUN on !halt_req. rf_halt deasserts the next cycle.

Reset (synchronous)
- Reset values: state=RUN, pending=0, scnt=0, rf_rd_wrn=1, rf_rd_offset=0, rf_data_in=0, rf_update_pc=0, rf_freeze_pc=1, rf_halt=0, halted=0.
- Reset mid-operation discards the in-flight output register contents and all pending bits.

Optional Feature:
REGFILE_CTRL_PERF_EN
- Defined: adds outputs perf_stall_cnt[31:0] (cycles with issue_valid && !issue_ready) and perf_conflict_cnt[31:0] (cycles with two or more requesters valid). Both saturate at 0xFFFFFFFF and clear on rst.
- Undefined: neither port nor counter exists.

Decomposition:
Shared package/include regfile_ctrl_pkg:
- XLEN, REG_ADDR_W=5
- FSM state encoding: RUN=2'd0, DRAIN=2'd1, HALTED=2'd2
- Requester index constants: JMP, WB, LSU

Sub-module rf_scoreboard: pending vector with set/clear ports and three hazard-lookup outputs. Arbiter and FSM stay in the top module.

Test Plan:
- Issue rd=5 (we=1), then issue rs1=5 next cycle → issue_ready=0 and rf_freeze_pc=1 until the wb grant for rd=5 is driven; issue is accepted the following cycle.
- jmp_valid and wb_valid together, jmp_target=0x40, wb_rd=3 → cycle N+1 rf_update_pc=1, rf_data_in=0x40; cycle N+2 rf_rd_wrn=0, rf_rd_offset=3.
- wb_valid held high continuously, lsu_valid high → lsu granted on the 5th cycle (STARVE_LIMIT=4); scnt returns to 0.
- wb write with rd=0, data 0xDEAD → rf_rd_offset=0 driven; scoreboard unchanged; issue with rs1=0 is never stalled.
- halt_req with two loads pending → state DRAIN, both lsu writes commit, then halted=1 and rf_halt=1; drop halt_req → RUN next cycle.
- rst asserted while in DRAIN with a pending write → next cycle all outputs at reset values, pending==0, issue_ready follows RUN rules.
